// File: rtl/io_uart_rx_port.sv
// Serial 8N1 receive port. Incoming bytes are buffered in a small FIFO.
// The FIFO head is presented as the IOIn word for WriteBack, which pops it on io_read.
module io_uart_rx_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          io_read,
    input  logic                          clr_err,
    output logic [31:0]                   io_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_HALF = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned CNT_LAST = CLKS_PER_BIT - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic [7:0]         shift, shift_n;
    logic               push_c, ferr_set_c;
    logic               rx_m, rx_s;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full_c, pop_c, do_push_c, ovr_set_c;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    // Frame sequencing: start-bit qualification at mid-bit, LSB-first data, stop check
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt + CNT_W'(1);
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (clk_cnt == CNT_W'(CNT_HALF)) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_W'(CNT_LAST)) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_W'(CNT_LAST)) begin
                    clk_cnt_n = '0;
                    if (rx_s) begin
                        push_c  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_n    = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                clk_cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO control: a pop frees room for a same-cycle push even when full
    always_comb begin
        full_c    = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
        pop_c     = io_read && (fifo_count != '0);
        do_push_c = push_c && (!full_c || pop_c);
        ovr_set_c = push_c && full_c && !pop_c;
    end

    // FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (ovr_set_c)    overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (ferr_set_c)   frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    // FIFO storage (contents are don't-care while not counted)
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= shift;
    end

    assign io_data = (fifo_count != '0) ? {23'b0, 1'b1, mem[rd_ptr]} : 32'b0;

endmodule

// File: tb/tb_io_uart_rx_port.sv
// Bench for io_uart_rx_port: directed scenarios plus random frames against a byte-queue model.
module tb_io_uart_rx_port;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_T   = 11 * CPB;                // frame plus one idle bit time
    localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;   // edge (from frame start) of the stop sample

    logic        clk = 1'b0;
    logic        reset, rx, io_read, clr_err;
    logic [31:0] io_data;
    logic [2:0]  fifo_count;
    logic        overrun, frame_err;

    int n_total = 0;
    int n_bad   = 0;

    byte unsigned q[$];
    bit           m_ovr, m_ferr;

    io_uart_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .io_read    (io_read),
        .clr_err    (clr_err),
        .io_data    (io_data),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_pop();
        if (q.size() != 0) void'(q.pop_front());
    endfunction

    function automatic void m_push(input byte unsigned b);
        if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(b);
    endfunction

    function automatic logic [31:0] m_data();
        return (q.size() != 0) ? (32'h100 | 32'(q[0])) : 32'h0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_data"},  io_data, m_data());
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "_ovr"},   32'(overrun), 32'(m_ovr));
        check({tag, "_ferr"},  32'(frame_err), 32'(m_ferr));
    endtask

    task automatic do_reset();
        reset = 1'b1; rx = 1'b1; io_read = 1'b0; clr_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop();
        io_read = 1'b1; tick(); io_read = 1'b0;
        m_pop();
    endtask

    task automatic clear_err();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic glitch();
        rx = 1'b0; tick();
        idle(3 * CPB);
    endtask

    // One 8N1 frame; io_read pulses on cycle pop_t of the frame (-1: none)
    task automatic send_frame(input byte unsigned b, input bit stop_ok, input int pop_t);
        for (int t = 0; t < FRAME_T; t++) begin
            int bi;
            bi = t / CPB;
            if (bi == 0)      rx = 1'b0;
            else if (bi <= 8) rx = b[bi-1];
            else if (bi == 9) rx = stop_ok;
            else              rx = 1'b1;
            io_read = (t == pop_t);
            tick();
        end
        io_read = 1'b0;
        if (pop_t >= 0 && pop_t <= STOP_EDGE - 1) m_pop();
        if (stop_ok) m_push(b);
        else m_ferr = 1'b1;
        if (pop_t > STOP_EDGE - 1) m_pop();
    endtask

    initial begin
        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            idle(10);
            check_all("idle");
        end

        // Single byte, then pop
        send_frame(8'hA5, 1'b1, -1);
        check("a5_data", io_data, 32'h1A5);
        check("a5_count", 32'(fifo_count), 32'd1);
        pop();
        check("a5_pop_data", io_data, 32'h0);
        check_all("a5_pop");

        // Overfill by one
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overrun), 32'd1);
        check("ovf_head", io_data, 32'h101);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", io_data, 32'h100 | 32'(i));
            pop();
        end
        check_all("ovf_empty");
        pop();
        check_all("underflow");
        clear_err();

        // Single-cycle low is not a start bit
        glitch();
        check_all("glitch");

        // Bad stop bit, recovery, clear
        send_frame(8'h3C, 1'b0, -1);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);
        idle(5);
        send_frame(8'h7E, 1'b1, -1);
        check("after_ferr", io_data, 32'h17E);
        clear_err();
        check("ferr_clr", 32'(frame_err), 32'd0);
        pop();

        // Pop coincident with push while full
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1);
        send_frame(8'h99, 1'b1, STOP_EDGE - 1);
        check("coin_count", 32'(fifo_count), 32'd4);
        check("coin_ovr", 32'(overrun), 32'd0);
        check_all("coin");
        pop(); pop(); pop();
        check("coin_tail", io_data, 32'h199);
        pop();

        // Reset in the middle of a data phase
        send_frame(8'h42, 1'b1, -1);
        for (int t = 0; t < 5 * CPB; t++) begin
            rx = (t < CPB) ? 1'b0 : (t[2] ^ t[0]);
            tick();
        end
        reset = 1'b1; rx = 1'b1; tick(); reset = 1'b0;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        idle(3 * CPB);
        check("rst_count", 32'(fifo_count), 32'd0);
        check_all("rst_mid");
        send_frame(8'hC3, 1'b1, -1);
        check("rst_clean", io_data, 32'h1C3);
        check_all("rst_after");

        // Random traffic
        for (int it = 0; it < 120; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch();
            end else begin
                byte unsigned b;
                bit ok;
                int pt;
                b  = 8'($urandom);
                ok = ($urandom_range(0, 9) != 0);
                pt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, FRAME_T - 1)) : -1;
                send_frame(b, ok, pt);
            end
            if ($urandom_range(0, 3) == 0) pop();
            if ($urandom_range(0, 7) == 0) clear_err();
            idle(int'($urandom_range(0, 3)));
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
